// File: rtl/mips_muldiv_unit.sv
// -----------------------------------------------------------------------------
// mips_muldiv_unit
//   Iterative multiply/divide unit with the HI/LO register pair of the MIPS
//   core. Executes mult, multu, div and divu in WIDTH+1 cycles
//   (WIDTH RUN iterations plus one FIX cycle) and provides the mthi/mtlo
//   write path and the mfhi/mflo read path.
//
// Handshake: start is a request that is taken only in a cycle where busy=0.
//   There is no queuing. start, hi_we and lo_we seen while busy=1 are
//   dropped. busy rises on the edge that takes start. It falls on the edge
//   that writes HI/LO. done is high for the single cycle that follows that
//   edge, and a new start is accepted in that same cycle.
//
// Ports:
//   clk, reset     core clock; synchronous active-high reset
//   start, op      launch request; op 00 mult, 01 multu, 10 div, 11 divu
//   operand_a/b    rs (multiplicand / dividend), rt (multiplier / divisor)
//   hi_we, lo_we   mthi / mtlo strobes, data on wdata
//   busy           operation in flight
//   done           one-cycle pulse after HI/LO were written by an operation
//   div_by_zero    valid with done; set when the finished divide had b=0
//   hi, lo         HI / LO registers (mfhi / mflo source)
//   state_dbg      current FSM state (0 IDLE, 1 RUN, 2 FIX)
// -----------------------------------------------------------------------------
module mips_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Operation context captured at start
    logic               is_div;
    logic               sa;
    logic               sb;
    logic               b_zero;
    logic [WIDTH-1:0]   a_orig;
    // Multiplicand magnitude for multiply, divisor magnitude for divide
    logic [WIDTH-1:0]   opnd;

    // Multiply: {partial product, remaining multiplier bits}.
    // Divide: only the low half is used, as the dividend/quotient shifter.
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   rem;
    logic [CNT_W-1:0]   cnt;

    // Operand magnitudes; sign flags only count for the signed ops
    logic               signed_op;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;

    assign signed_op = ~op[0];
    assign a_neg     = signed_op & operand_a[WIDTH-1];
    assign b_neg     = signed_op & operand_b[WIDTH-1];
    assign abs_a     = a_neg ? -operand_a : operand_a;
    assign abs_b     = b_neg ? -operand_b : operand_b;

    // One shift-add step: add the multiplicand into the upper half when the
    // current multiplier bit is set, then shift the whole pair right.
    logic [WIDTH:0]     mul_sum;
    assign mul_sum = {1'b0, prod[2*WIDTH-1:WIDTH]}
                   + (prod[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});

    // One restoring-division step over a WIDTH+1 bit partial remainder. The
    // remainder is always below the divisor, so the shifted value fits in
    // WIDTH+1 bits and bit WIDTH of the difference is a valid borrow.
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;
    logic               div_ok;
    assign div_shift = {rem, prod[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, opnd};
    assign div_ok    = ~div_trial[WIDTH];

    // Sign fix applied in FIX
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    assign prod_fix = (sa ^ sb) ? -prod : prod;
    assign quo_fix  = (sa ^ sb) ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
    assign rem_fix  = sa ? -rem : rem;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            // cnt==1 means this edge performs the last iteration
            RUN:  if (cnt == CNT_W'(1)) state_nxt = FIX;
            FIX:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            cnt         <= '0;
            is_div      <= 1'b0;
            sa          <= 1'b0;
            sb          <= 1'b0;
            b_zero      <= 1'b0;
            a_orig      <= '0;
            opnd        <= '0;
            prod        <= '0;
            rem         <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        is_div <= op[1];
                        sa     <= a_neg;
                        sb     <= b_neg;
                        b_zero <= (operand_b == '0);
                        a_orig <= operand_a;
                        cnt    <= CNT_W'(WIDTH);
                        rem    <= '0;
                        if (op[1]) begin
                            prod <= {{WIDTH{1'b0}}, abs_a};
                            opnd <= abs_b;
                        end else begin
                            prod <= {{WIDTH{1'b0}}, abs_b};
                            opnd <= abs_a;
                        end
                    end else begin
                        // start wins over mthi/mtlo in the same cycle
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                RUN: begin
                    cnt <= cnt - CNT_W'(1);
                    if (is_div) begin
                        rem              <= div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
                        prod[WIDTH-1:0]  <= {prod[WIDTH-2:0], div_ok};
                    end else begin
                        prod <= {mul_sum, prod[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    done <= 1'b1;
                    if (is_div && b_zero) begin
                        hi          <= a_orig;
                        lo          <= '1;
                        div_by_zero <= 1'b1;
                    end else if (is_div) begin
                        hi          <= rem_fix;
                        lo          <= quo_fix;
                        div_by_zero <= 1'b0;
                    end else begin
                        hi          <= prod_fix[2*WIDTH-1:WIDTH];
                        lo          <= prod_fix[WIDTH-1:0];
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_mips_muldiv_unit
//   Bench for mips_muldiv_unit: a WIDTH=32 instance with a directed vector
//   table, hand-written busy/reset sequences and random operations checked
//   against an arithmetic reference model, plus a WIDTH=8 instance.
// -----------------------------------------------------------------------------
module tb_mips_muldiv_unit;

    localparam int W = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;

    // WIDTH=32 instance
    logic        start, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic        busy, done, dbz;
    logic [31:0] hi, lo;
    logic [1:0]  state_dbg;

    // WIDTH=8 instance
    logic        start8, hi_we8, lo_we8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8, wdata8;
    logic        busy8, done8, dbz8;
    logic [7:0]  hi8, lo8;
    logic [1:0]  state_dbg8;

    mips_muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .operand_a(a), .operand_b(b), .hi_we(hi_we), .lo_we(lo_we),
        .wdata(wdata), .busy(busy), .done(done), .div_by_zero(dbz),
        .hi(hi), .lo(lo), .state_dbg(state_dbg)
    );

    mips_muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8),
        .operand_a(a8), .operand_b(b8), .hi_we(hi_we8), .lo_we(lo_we8),
        .wdata(wdata8), .busy(busy8), .done(done8), .div_by_zero(dbz8),
        .hi(hi8), .lo(lo8), .state_dbg(state_dbg8)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [64:0] exp_q[$];   // {div_by_zero, hi, lo}

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: plain arithmetic on sign/zero-extended 64-bit values.
    // Returns {div_by_zero, hi, lo} with hi/lo in the low w bits of each field.
    function automatic logic [64:0] model(input int w, input logic [1:0] o,
                                          input logic [31:0] x, input logic [31:0] y);
        logic [63:0] mask, a64, b64, p, q, r, rh, rl;
        logic        sgn, z;
        mask = (64'd1 << w) - 64'd1;
        sgn  = ~o[0];
        a64  = {32'd0, x} & mask;
        b64  = {32'd0, y} & mask;
        if (sgn && x[w-1]) a64 = a64 | ~mask;
        if (sgn && y[w-1]) b64 = b64 | ~mask;
        z = 1'b0;
        if (!o[1]) begin
            p  = a64 * b64;
            rh = (p >> w) & mask;
            rl = p & mask;
        end else if ((b64 & mask) == 64'd0) begin
            z  = 1'b1;
            rh = {32'd0, x} & mask;
            rl = mask;
        end else begin
            if (sgn) begin
                q = $signed(a64) / $signed(b64);
                r = $signed(a64) % $signed(b64);
            end else begin
                q = a64 / b64;
                r = a64 % b64;
            end
            rh = r & mask;
            rl = q & mask;
        end
        return {z, rh[31:0], rl[31:0]};
    endfunction

    // ---------------- driver tasks ----------------
    // Issue one operation on the 32-bit unit as soon as it is free, then
    // check latency, busy duration, HI/LO hold during the run and the result
    // against the head of exp_q.
    task automatic run32(input string name, input logic [1:0] o,
                         input logic [31:0] x, input logic [31:0] y);
        int n, busy_n;
        logic held;
        logic [31:0] ph, pl;
        logic [64:0] e;
        n = 0;
        while (busy && n < 200) begin @(posedge clk); #1; n++; end
        check({name, " ready"}, busy, 0);
        ph = hi; pl = lo;
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({name, " done low after start"}, done, 0);
        busy_n = busy ? 1 : 0;
        held = (hi === ph) && (lo === pl);
        n = 0;
        while (!done && n < 3 * W) begin
            @(posedge clk); #1;
            n++;
            if (!done) begin
                busy_n += busy ? 1 : 0;
                held = held && (hi === ph) && (lo === pl);
            end
        end
        check({name, " latency"}, n, W + 1);
        check({name, " busy cycles"}, busy_n, W + 1);
        check({name, " hi/lo held"}, held, 1);
        check({name, " busy at done"}, busy, 0);
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: expected queue empty", name);
        end else begin
            e = exp_q.pop_front();
            check({name, " hi"}, hi, e[63:32]);
            check({name, " lo"}, lo, e[31:0]);
            check({name, " div_by_zero"}, dbz, e[64]);
        end
    endtask

    task automatic run8(input string name, input logic [1:0] o, input logic [7:0] x,
                        input logic [7:0] y, input logic [7:0] eh, input logic [7:0] el,
                        input logic ed);
        int n;
        n = 0;
        while (busy8 && n < 50) begin @(posedge clk); #1; n++; end
        op8 = o; a8 = x; b8 = y; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        n = 0;
        while (!done8 && n < 50) begin @(posedge clk); #1; n++; end
        check({name, " latency"}, n, 9);
        check({name, " hi"}, hi8, eh);
        check({name, " lo"}, lo8, el);
        check({name, " div_by_zero"}, dbz8, ed);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    // ---------------- directed vectors ----------------
    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a, b, hi, lo;
        logic        dbz;
    } vec_t;

    vec_t vecs[13];

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    // ---------------- main sequence ----------------
    initial begin
        int n, extra;
        logic [64:0] r;
        logic [1:0]  o;
        logic [31:0] x, y;

        vecs[0]  = '{"multu ffffffff^2", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[1]  = '{"mult -3*5",        2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
        vecs[2]  = '{"mult 8000^2",      2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[3]  = '{"div -7/2",         2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[4]  = '{"divu 7/2",         2'b11, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 1'b0};
        vecs[5]  = '{"div minneg/-1",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[6]  = '{"divu 5/0",         2'b11, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1};
        vecs[7]  = '{"div -7/0",         2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
        vecs[8]  = '{"div 7/-2",         2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
        vecs[9]  = '{"mult 7*-1",        2'b00, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b0};
        vecs[10] = '{"mult -5*0",        2'b00, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[11] = '{"divu ffffffff/1",  2'b11, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
        vecs[12] = '{"multu 8000*2",     2'b01, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000, 1'b0};

        reset = 1'b1;
        start = 0; hi_we = 0; lo_we = 0; op = 0; a = 0; b = 0; wdata = 0;
        start8 = 0; hi_we8 = 0; lo_we8 = 0; op8 = 0; a8 = 0; b8 = 0; wdata8 = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset hi", hi, 0);
        check("reset lo", lo, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset div_by_zero", dbz, 0);
        check("reset state", state_dbg, 0);
        check("reset busy w8", busy8, 0);
        check("reset hi w8", hi8, 0);
        reset = 1'b0;

        // mthi/mtlo together, then mthi alone; no bypass of wdata
        hi_we = 1; lo_we = 1; wdata = 32'h5678;
        check("mt no bypass", hi, 0);
        @(posedge clk); #1;
        check("mt both hi", hi, 32'h5678);
        check("mt both lo", lo, 32'h5678);
        lo_we = 0; wdata = 32'h1234;
        @(posedge clk); #1;
        hi_we = 0;
        check("mthi hi", hi, 32'h1234);
        check("mthi lo", lo, 32'h5678);

        // directed table, issued back to back
        for (int i = 0; i < 13; i++) begin
            exp_q.push_back({vecs[i].dbz, vecs[i].hi, vecs[i].lo});
            run32(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b);
        end

        // start + mthi/mtlo while busy: ignored, nothing queued
        op = 2'b01; a = 32'h10; b = 32'h3; start = 1;
        @(posedge clk); #1;
        start = 0;
        repeat (4) begin @(posedge clk); #1; end
        start = 1; op = 2'b11; a = 9; b = 0; hi_we = 1; lo_we = 1; wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        start = 0; hi_we = 0; lo_we = 0;
        n = 5;
        while (!done && n < 200) begin @(posedge clk); #1; n++; end
        check("busy strobes latency", n, 33);
        check("busy strobes hi", hi, 0);
        check("busy strobes lo", lo, 32'h30);
        check("busy strobes div_by_zero", dbz, 0);
        extra = 0;
        repeat (40) begin @(posedge clk); #1; if (busy || done) extra++; end
        check("busy strobes no queued op", extra, 0);
        check("busy strobes lo kept", lo, 32'h30);

        // reset during RUN
        exp_q.push_back({1'b1, 32'h5, 32'hFFFF_FFFF});
        run32("pre-reset divu 5/0", 2'b11, 32'h5, 32'h0);
        op = 2'b01; a = 32'hFFFF; b = 32'hFFFF; start = 1;
        @(posedge clk); #1;
        start = 0;
        repeat (10) begin @(posedge clk); #1; end
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        check("mid reset busy", busy, 0);
        check("mid reset done", done, 0);
        check("mid reset hi", hi, 0);
        check("mid reset lo", lo, 0);
        check("mid reset div_by_zero", dbz, 0);
        check("mid reset state", state_dbg, 0);
        extra = 0;
        repeat (40) begin @(posedge clk); #1; if (done || busy) extra++; end
        check("mid reset no done", extra, 0);

        // start takes priority over strobes in the same cycle
        hi_we = 1; lo_we = 1; wdata = 32'hAAAA;
        exp_q.push_back({1'b0, 32'h0, 32'd42});
        run32("post-reset multu 6x7", 2'b01, 32'd6, 32'd7);
        hi_we = 0; lo_we = 0;

        // random operations against the reference model
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            x = pick();
            y = pick();
            exp_q.push_back(model(32, o, x, y));
            run32($sformatf("rand%0d op%0d", i, o), o, x, y);
        end

        // WIDTH=8 instance
        run8("w8 multu ff*ff", 2'b01, 8'hFF, 8'hFF, 8'hFE, 8'h01, 1'b0);
        run8("w8 div 80/ff",   2'b10, 8'h80, 8'hFF, 8'h00, 8'h80, 1'b0);
        run8("w8 mult -3*5",   2'b00, 8'hFD, 8'h05, 8'hFF, 8'hF1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            o = 2'($urandom_range(0, 3));
            x = {24'd0, 8'($urandom)};
            y = (i % 5 == 0) ? 32'd0 : {24'd0, 8'($urandom)};
            r = model(8, o, x, y);
            run8($sformatf("w8 rand%0d op%0d", i, o), o, x[7:0], y[7:0], r[39:32], r[7:0], r[64]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
